ternary_operand_packer: RTL and testbench
=========================================

TERNARY_OPERAND_PACKER -- requirements
Module: ternary_operand_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and data width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream word valid.
REQ-005 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  operand word.
REQ-007 SHALL have port in_last  input  1  final word of a packet.
REQ-008 SHALL have port out_valid  output  1  operand triple presented.
REQ-009 SHALL have port out_ready  input  1  downstream ternary adder stage accepts the triple.
REQ-010 SHALL have ports out_a, out_b, out_c  output  WIDTH each  operands in arrival order: first, second, third.
REQ-011 SHALL have port out_cnt  output  2  number of real operands in the triple (1..3).
REQ-012 SHALL have port out_last  output  1  triple holds the final word of its packet.

Function
REQ-013 SHALL accept a word ("in transfer") only when in_valid and in_ready are both high on a rising clk edge.
REQ-014 SHALL complete an "out transfer" only when out_valid and out_ready are both high on a rising clk edge.
REQ-015 SHALL drive in_ready = !out_valid || out_ready, combinationally.
  - in_ready does not depend on in_valid, in_data or in_last.
REQ-016 SHALL track the fill position with a slot state machine: S0 (empty), S1 (one word staged), S2 (two words staged).
REQ-017 SHALL handle an in transfer in S0 with in_last=0 by staging the word as operand a and moving to S1.
REQ-018 SHALL handle an in transfer in S1 with in_last=0 by staging the word as operand b and moving to S2.
REQ-019 SHALL treat an in transfer in S2, or any in transfer with in_last=1, as completing.
  - Completing means: load the output registers, set out_valid=1, return to S0.
REQ-020 SHALL, on completion, set the output registers as follows:
  - out_a/out_b/out_c = staged words, then the current word, then zeros for every unfilled position.
  - out_cnt = 1, 2 or 3 to match the number of real words.
  - out_last = in_last of the completing word.
REQ-021 SHALL zero-pad unfilled operands so that out_a+out_b+out_c equals the exact sum of the real operands.
REQ-022 SHALL hold out_a, out_b, out_c, out_cnt and out_last stable while out_valid=1 and out_ready=0.
REQ-023 SHALL clear out_valid after an out transfer unless a completing in transfer occurs in the same cycle.
  - If such a completion occurs, the new triple is loaded and out_valid stays 1 (back-to-back, no bubble).
REQ-024 SHALL sustain one accepted word per cycle while out_ready is held high.
REQ-025 SHALL ignore in_data and in_last whenever no in transfer occurs; staged words never change outside an in transfer.
REQ-026 SHALL never output a triple with out_cnt=0.
  - A packet of N words yields ceil(N/3) triples.
  - Only the packet's final triple has out_last=1.
REQ-027 SHALL pass data unmodified.
  - No arithmetic, no width change.
  - out_* are registered outputs, with no combinational path from in_data.
REQ-028 SHALL have a latency of one cycle: the triple appears on the edge that accepts its completing word.

Reset
REQ-029 SHALL, while rst=1, asynchronously force all of the following, with no clock edge needed:
  - out_valid=0, out_a=out_b=out_c=0, out_cnt=0, out_last=0;
  - slot state to S0, staged words to 0.
REQ-030 SHALL drive in_ready=1 during and immediately after reset.
REQ-031 SHALL discard partially staged words and any unaccepted triple when reset is asserted mid-operation.
  - After release, packing restarts from S0.

Verification
REQ-032 SHALL cover this scenario, with out_ready=1 held:
  - Stimulus: words 5, 7, 9 on consecutive cycles, in_last on 9.
  - Required response: one triple a=5 b=7 c=9, cnt=3, last=1, one cycle after 9 is accepted.
REQ-033 SHALL cover this scenario:
  - Stimulus: packet 1, 2, 3, 4 (in_last on 4).
  - Required response: triple (1,2,3) cnt=3 last=0, then triple (4,0,0) cnt=1 last=1.
REQ-034 SHALL cover this scenario:
  - Stimulus: packet 0xFFFFFFFF, 0x1 (last on 0x1).
  - Required response: triple (0xFFFFFFFF,0x1,0) cnt=2 last=1; a downstream sum of 0x00000000 is observed.
REQ-035 SHALL cover this scenario:
  - Stimulus: out_ready=0 for 4 cycles while a completed triple is pending and in_valid stays high.
  - Required response: in_ready=0, outputs stable, no word lost, no word duplicated; 6 words 10..15 then yield exactly (10,11,12) and (13,14,15).
REQ-036 SHALL cover this scenario:
  - Stimulus: rst pulsed asynchronously (between edges) while in S2 with words 20, 21 staged.
  - Required response: out_valid=0 immediately; next packet 30 (last) yields (30,0,0) cnt=1 with no trace of 20, 21.
REQ-037 SHALL cover this scenario:
  - Stimulus: random in_valid/out_ready, 1000 packets of random length 1..10, WIDTH=32.
  - Required response: a scoreboard confirms ordering, padding, out_cnt and out_last for every triple.

Source files
------------

// File: rtl/ternary_operand_packer.sv
// Groups a word stream into operand triples for a downstream ternary adder.
// Short groups are zero-padded so the triple sum equals the sum of the real words.
module ternary_operand_packer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [1:0]       out_cnt,
  output logic             out_last
);

  typedef enum logic [1:0] {
    S0,
    S1,
    S2
  } slot_e;

  slot_e            state;
  slot_e            state_next;
  logic [WIDTH-1:0] stage_a;
  logic [WIDTH-1:0] stage_b;
  logic             in_xfer;
  logic             out_xfer;
  logic             complete;

  // A new triple may be loaded whenever the output register is empty or draining.
  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign complete = in_xfer && (in_last || (state == S2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (in_xfer) begin
      if (complete) begin
        state_next = S0;
      end else begin
        case (state)
          S0:      state_next = S1;
          S1:      state_next = S2;
          default: state_next = S0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_a <= '0;
      stage_b <= '0;
    end else if (in_xfer && !complete) begin
      case (state)
        S0:      stage_a <= in_data;
        S1:      stage_b <= in_data;
        default: ;
      endcase
    end
  end

  // Output registers only change on completion, which cannot happen while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      out_cnt   <= 2'd0;
      out_last  <= 1'b0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_last  <= in_last;
      case (state)
        S0: begin
          out_a   <= in_data;
          out_b   <= '0;
          out_c   <= '0;
          out_cnt <= 2'd1;
        end
        S1: begin
          out_a   <= stage_a;
          out_b   <= in_data;
          out_c   <= '0;
          out_cnt <= 2'd2;
        end
        default: begin
          out_a   <= stage_a;
          out_b   <= stage_b;
          out_c   <= in_data;
          out_cnt <= 2'd3;
        end
      endcase
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ternary_operand_packer.sv
// Directed and randomized checks for ternary_operand_packer; triples are captured
// by a monitor and compared against hand-computed or model-generated expectations.
module tb_ternary_operand_packer;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [1:0]       cnt;
    logic             last;
  } trip_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [1:0]       out_cnt;
  logic             out_last;

  int    checks = 0;
  int    errors = 0;
  bit    rand_ready = 1'b0;
  trip_t got_q[$];
  trip_t exp_q[$];

  always #5 clk = ~clk;

  ternary_operand_packer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_cnt   (out_cnt),
    .out_last  (out_last)
  );

  // Record every completed out transfer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      got_q.push_back({out_a, out_b, out_c, out_cnt, out_last});
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input logic l, output int cyc);
    bit acc;
    bit done;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    cyc      = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      acc = in_ready;
      step();
      cyc++;
      if (acc) begin
        done = 1'b1;
      end else if (cyc >= 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: word %0h not accepted after %0d cycles, required acceptance", d, cyc);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'($urandom_range(0, 1));
    repeat (n) step();
  endtask

  task automatic wait_drain(input int n, input int limit);
    int k = 0;
    in_valid = 1'b0;
    while (got_q.size() < n && k < limit) begin
      step();
      k++;
    end
    checks++;
    if (got_q.size() != n) begin
      errors++;
      $display("[TB] FAIL triple_count: got %0d triples, expected %0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", out_valid); end
    checks++; if (out_a !== '0) begin errors++; $display("[TB] FAIL rst_a: got %0h expected 0", out_a); end
    checks++; if (out_b !== '0) begin errors++; $display("[TB] FAIL rst_b: got %0h expected 0", out_b); end
    checks++; if (out_c !== '0) begin errors++; $display("[TB] FAIL rst_c: got %0h expected 0", out_c); end
    checks++; if (out_cnt !== 2'd0) begin errors++; $display("[TB] FAIL rst_cnt: got %0d expected 0", out_cnt); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_last: got %b expected 0", out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    int c;
    trip_t e;
    out_ready = 1'b1;
    got_q.delete();
    send_word(32'd5, 1'b0, c);
    send_word(32'd7, 1'b0, c);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: got %b expected 0", out_valid); end
    send_word(32'd9, 1'b1, c);
    e = {32'd5, 32'd7, 32'd9, 2'd3, 1'b1};
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency: out_valid got %b expected 1", out_valid); end
    checks++;
    if ({out_a, out_b, out_c, out_cnt, out_last} !== e) begin
      errors++; $display("[TB] FAIL basic_outputs: got %h expected %h", {out_a, out_b, out_c, out_cnt, out_last}, e);
    end
    wait_drain(1, 20);
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== e) begin errors++; $display("[TB] FAIL basic_triple: got %h expected %h", got_q[0], e); end
    end
  endtask

  task automatic test_multi();
    int c;
    trip_t e0, e1;
    out_ready = 1'b1;
    got_q.delete();
    send_word(32'd1, 1'b0, c);
    send_word(32'd2, 1'b0, c);
    send_word(32'd3, 1'b0, c);
    send_word(32'd4, 1'b1, c);
    e0 = {32'd1, 32'd2, 32'd3, 2'd3, 1'b0};
    e1 = {32'd4, 32'd0, 32'd0, 2'd1, 1'b1};
    wait_drain(2, 20);
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0] !== e0) begin errors++; $display("[TB] FAIL multi_first: got %h expected %h", got_q[0], e0); end
      checks++; if (got_q[1] !== e1) begin errors++; $display("[TB] FAIL multi_second: got %h expected %h", got_q[1], e1); end
    end
  endtask

  task automatic test_overflow();
    int c;
    trip_t e;
    logic [WIDTH-1:0] s;
    out_ready = 1'b1;
    got_q.delete();
    send_word(32'hFFFF_FFFF, 1'b0, c);
    send_word(32'h0000_0001, 1'b1, c);
    e = {32'hFFFF_FFFF, 32'h1, 32'h0, 2'd2, 1'b1};
    wait_drain(1, 20);
    if (got_q.size() >= 1) begin
      s = got_q[0].a + got_q[0].b + got_q[0].c;
      checks++; if (got_q[0] !== e) begin errors++; $display("[TB] FAIL overflow_triple: got %h expected %h", got_q[0], e); end
      checks++; if (s !== 32'h0) begin errors++; $display("[TB] FAIL overflow_sum: got %h expected 00000000", s); end
    end
  endtask

  task automatic test_backpressure();
    int c;
    trip_t e0, e1;
    e0 = {32'd10, 32'd11, 32'd12, 2'd3, 1'b0};
    e1 = {32'd13, 32'd14, 32'd15, 2'd3, 1'b1};
    out_ready = 1'b0;
    got_q.delete();
    send_word(32'd10, 1'b0, c);
    send_word(32'd11, 1'b0, c);
    send_word(32'd12, 1'b0, c);
    in_valid = 1'b1; in_data = 32'd13; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++;
      if ({out_a, out_b, out_c, out_cnt, out_last} !== e0) begin
        errors++; $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", i, {out_a, out_b, out_c, out_cnt, out_last}, e0);
      end
      step();
    end
    out_ready = 1'b1;
    send_word(32'd13, 1'b0, c);
    send_word(32'd14, 1'b0, c);
    send_word(32'd15, 1'b1, c);
    wait_drain(2, 20);
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0] !== e0) begin errors++; $display("[TB] FAIL stall_first: got %h expected %h", got_q[0], e0); end
      checks++; if (got_q[1] !== e1) begin errors++; $display("[TB] FAIL stall_second: got %h expected %h", got_q[1], e1); end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int total = 0;
    trip_t e0, e1;
    e0 = {32'd1, 32'd2, 32'd3, 2'd3, 1'b0};
    e1 = {32'd4, 32'd5, 32'd6, 2'd3, 1'b1};
    out_ready = 1'b1;
    got_q.delete();
    for (int i = 1; i <= 6; i++) begin
      send_word(WIDTH'(i), (i == 6), c);
      total += c;
      if (i == 4) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_valid_drop: got %b expected 0", out_valid); end
      end
    end
    checks++; if (total != 6) begin errors++; $display("[TB] FAIL b2b_cycles: got %0d expected 6", total); end
    wait_drain(2, 20);
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0] !== e0) begin errors++; $display("[TB] FAIL b2b_first: got %h expected %h", got_q[0], e0); end
      checks++; if (got_q[1] !== e1) begin errors++; $display("[TB] FAIL b2b_second: got %h expected %h", got_q[1], e1); end
    end
  endtask

  task automatic test_async_reset();
    int c;
    trip_t e;
    got_q.delete();
    out_ready = 1'b0;
    send_word(32'd50, 1'b1, c);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_pending_valid: got %b expected 0", out_valid); end
    checks++; if (out_a !== '0) begin errors++; $display("[TB] FAIL arst_pending_a: got %0h expected 0", out_a); end
    checks++; if (out_cnt !== 2'd0) begin errors++; $display("[TB] FAIL arst_pending_cnt: got %0d expected 0", out_cnt); end
    #2 rst = 1'b0;
    step();
    out_ready = 1'b1;
    send_word(32'd20, 1'b0, c);
    send_word(32'd21, 1'b0, c);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_staged_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst_in_ready: got %b expected 1", in_ready); end
    #2 rst = 1'b0;
    step();
    send_word(32'd30, 1'b1, c);
    e = {32'd30, 32'd0, 32'd0, 2'd1, 1'b1};
    wait_drain(1, 20);
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== e) begin errors++; $display("[TB] FAIL arst_restart: got %h expected %h", got_q[0], e); end
    end
  endtask

  task automatic test_random();
    int c;
    int len;
    int n;
    int m;
    logic [WIDTH-1:0] w, b0, b1, b2;
    logic lst;
    got_q.delete();
    exp_q.delete();
    rand_ready = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 10);
      n = 0;
      for (int i = 0; i < len; i++) begin
        w   = $urandom;
        lst = (i == len - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
        send_word(w, lst, c);
        if (n == 0) b0 = w; else if (n == 1) b1 = w; else b2 = w;
        n++;
        if (n == 3 || lst) begin
          exp_q.push_back({b0, (n > 1) ? b1 : '0, (n > 2) ? b2 : '0, 2'(n), lst});
          n = 0;
        end
      end
    end
    wait_drain(exp_q.size(), 500);
    rand_ready = 1'b0;
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("[TB] FAIL random_triple[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
